config_bitbang_rx: RTL



---
 rtl/config_bitbang_rx.sv | 110 +++++++++++
 1 files changed

// File: rtl/config_bitbang_rx.sv
// Bit-bang config receiver: data shifts on host s_clk rises, control on falls; control words open/close a session and emit words.
// Latency: s_clk edge to shift is 3 CLK, decode acts 1 CLK later; no backpressure, strobe is a one-cycle pulse.
module config_bitbang_rx #(
  parameter int              DATA_W      = 32,
  parameter int              CTRL_W      = 16,
  parameter logic [CTRL_W-1:0] WORD_STROBE = 16'hFAB0,
  parameter logic [CTRL_W-1:0] WORD_ENTER  = 16'hFAB1,
  parameter logic [CTRL_W-1:0] WORD_EXIT   = 16'hFAB2,
  parameter int              TIMEOUT_W   = 20
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              s_clk,
  input  logic              s_data,
  output logic [DATA_W-1:0] data,
  output logic              strobe,
  output logic              active,
  output logic              timed_out
);

  logic                 sc1_q, sc2_q, sc3_q, sd1_q, sd2_q;
  logic [DATA_W-1:0]    data_sr_q, data_sr_d;
  logic [CTRL_W-1:0]    ctrl_sr_q, ctrl_sr_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 strobe_q, strobe_d;
  logic                 active_q, active_d;
  logic                 timed_out_q, timed_out_d;
  logic [TIMEOUT_W-1:0] idle_q, idle_d, idle_inc;
  logic                 rise, fall, hit_strobe, hit_enter, hit_exit;

  always_comb begin
    rise        = sc2_q & ~sc3_q;
    fall        = ~sc2_q & sc3_q;
    hit_strobe  = (ctrl_sr_q == WORD_STROBE);
    hit_enter   = (ctrl_sr_q == WORD_ENTER);
    hit_exit    = (ctrl_sr_q == WORD_EXIT);
    idle_inc    = idle_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    data_sr_d   = rise ? {data_sr_q[DATA_W-2:0], sd2_q} : data_sr_q;
    data_d      = data_q;
    strobe_d    = 1'b0;
    active_d    = active_q;
    timed_out_d = 1'b0;
    idle_d      = idle_q;

    // A decoded word clears the control register; a fall in the same cycle is dropped.
    if (hit_strobe || hit_enter || hit_exit)
      ctrl_sr_d = '0;
    else if (fall)
      ctrl_sr_d = {ctrl_sr_q[CTRL_W-2:0], sd2_q};
    else
      ctrl_sr_d = ctrl_sr_q;

    if (hit_enter)
      active_d = 1'b1;
    if (hit_exit)
      active_d = 1'b0;
    if (hit_strobe && active_q) begin
      strobe_d = 1'b1;
      data_d   = data_sr_q;
    end

    // Idle timeout overrides any session decode in the same cycle.
    if (!active_q || rise || fall) begin
      idle_d = '0;
    end else if (&idle_inc) begin
      idle_d      = '0;
      active_d    = 1'b0;
      timed_out_d = 1'b1;
    end else begin
      idle_d = idle_inc;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      sc1_q       <= 1'b0;
      sc2_q       <= 1'b0;
      sc3_q       <= 1'b0;
      sd1_q       <= 1'b0;
      sd2_q       <= 1'b0;
      data_sr_q   <= '0;
      ctrl_sr_q   <= '0;
      data_q      <= '0;
      strobe_q    <= 1'b0;
      active_q    <= 1'b0;
      timed_out_q <= 1'b0;
      idle_q      <= '0;
    end else begin
      sc1_q       <= s_clk;
      sc2_q       <= sc1_q;
      sc3_q       <= sc2_q;
      sd1_q       <= s_data;
      sd2_q       <= sd1_q;
      data_sr_q   <= data_sr_d;
      ctrl_sr_q   <= ctrl_sr_d;
      data_q      <= data_d;
      strobe_q    <= strobe_d;
      active_q    <= active_d;
      timed_out_q <= timed_out_d;
      idle_q      <= idle_d;
    end
  end

  assign data      = data_q;
  assign strobe    = strobe_q;
  assign active    = active_q;
  assign timed_out = timed_out_q;

endmodule
